// File: rtl/addsub_arbiter.sv
// ---------------------------------------------------------------------------
// addsub_arbiter.sv
//
// Round-robin arbiter and sequencer that shares a single 16-bit
// adder/subtractor (SixTeenBitAddSub) among up to four requesters.
// One command is in flight at a time: it is accepted in IDLE, its operands
// are registered, the shared adder runs in EXEC, and the result is presented
// in RESP until the consumer takes it.
//
// Files contents:
//   SixTeenBitAddSub - ripple-carry 16-bit add/sub with carry and overflow
//   addsub_arbiter   - top: arbiter, FSM, response registers, ovf counter
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// SixTeenBitAddSub
//   Two's-complement 16-bit adder/subtractor. Subtraction is A + ~B + 1, so
//   carry means "no borrow" when mode = 1.
//
// Ports:
//   inputA   in  16  operand A
//   inputB   in  16  operand B
//   mode     in   1  0 = A+B, 1 = A-B
//   sum      out 16  result modulo 2^16
//   carry    out  1  carry out of bit 15
//   overflow out  1  signed overflow (carry into bit 15 XOR carry out)
// ---------------------------------------------------------------------------
module SixTeenBitAddSub (
    input  logic [15:0] inputA,
    input  logic [15:0] inputB,
    input  logic        mode,
    output logic [15:0] sum,
    output logic        carry,
    output logic        overflow
);

    logic [15:0] b_eff;
    logic [16:0] c;

    assign b_eff = inputB ^ {16{mode}};

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = mode;
        for (int unsigned i = 0; i < 16; i++) begin
            sum[i]   = inputA[i] ^ b_eff[i] ^ c[i];
            c[i + 1] = (inputA[i] & b_eff[i]) | ((inputA[i] ^ b_eff[i]) & c[i]);
        end
    end

    assign carry    = c[16];
    assign overflow = c[16] ^ c[15];

endmodule

// ---------------------------------------------------------------------------
// addsub_arbiter
//
// Parameters:
//   NREQ  number of requesters (2..4)
//   CNTW  width of the saturating overflow counter
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   req_valid  in   NREQ       per-requester command valid
//   req_ready  out  NREQ       per-requester accept, one-hot or zero
//   req_a      in   16*NREQ    operand A, requester i at [16i+15:16i]
//   req_b      in   16*NREQ    operand B, same packing
//   req_mode   in   NREQ       0 = A+B, 1 = A-B
//   rsp_valid  out  1          response valid
//   rsp_ready  in   1          response consumer ready
//   rsp_id     out  2          requester index of the response
//   rsp_sum    out  16         adder sum
//   rsp_carry  out  1          adder carry-out
//   rsp_ovf    out  1          signed overflow
//   busy       out  1          high in EXEC or RESP
//   ovf_cnt    out  CNTW       saturating count of overflowing responses
// ---------------------------------------------------------------------------
module addsub_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CNTW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_mode,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_id,
    output logic [15:0]          rsp_sum,
    output logic                 rsp_carry,
    output logic                 rsp_ovf,
    output logic                 busy,
    output logic [CNTW-1:0]      ovf_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  rr_ptr;

    // operand registers feeding the shared adder
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_mode;
    logic [1:0]  op_id;

    // arbitration results
    logic [3:0]  valid4;
    logic        grant_vld;
    logic [1:0]  winner;
    logic [2:0]  scan_idx;
    logic [2:0]  ptr_inc;
    logic [1:0]  ptr_next;
    logic [3:0]  ready4;

    // selected operands of the winner
    logic [15:0] sel_a;
    logic [15:0] sel_b;
    logic        sel_mode;

    // shared adder outputs
    logic [15:0] add_sum;
    logic        add_carry;
    logic        add_ovf;

    assign valid4 = 4'(req_valid);

    // Scan from rr_ptr upward, wrapping modulo NREQ; first valid bit wins.
    always_comb begin
        grant_vld = 1'b0;
        winner    = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + 3'(k);
            if (scan_idx >= 3'(NREQ)) begin
                scan_idx = scan_idx - 3'(NREQ);
            end
            if (!grant_vld && valid4[scan_idx[1:0]]) begin
                grant_vld = 1'b1;
                winner    = scan_idx[1:0];
            end
        end
    end

    always_comb begin
        ptr_inc  = {1'b0, winner} + 3'd1;
        ptr_next = (ptr_inc >= 3'(NREQ)) ? 2'd0 : ptr_inc[1:0];
    end

    // Ready is combinational in IDLE; gated by rst_n so it reads zero while
    // reset is held even though the state register already sits in IDLE.
    always_comb begin
        ready4 = '0;
        if (rst_n && (state == IDLE) && grant_vld) begin
            ready4[winner] = 1'b1;
        end
    end

    assign req_ready = ready4[NREQ-1:0];

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_mode = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner == 2'(i)) begin
                sel_a    = req_a[16*i +: 16];
                sel_b    = req_b[16*i +: 16];
                sel_mode = req_mode[i];
            end
        end
    end

    SixTeenBitAddSub u_addsub (
        .inputA   (op_a),
        .inputB   (op_b),
        .mode     (op_mode),
        .sum      (add_sum),
        .carry    (add_carry),
        .overflow (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_mode   <= 1'b0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
            busy      <= 1'b0;
            ovf_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        op_mode <= sel_mode;
                        op_id   <= winner;
                        rr_ptr  <= ptr_next;
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= add_sum;
                    rsp_carry <= add_carry;
                    rsp_ovf   <= add_ovf;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                    if (add_ovf && (ovf_cnt != '1)) begin
                        ovf_cnt <= ovf_cnt + CNTW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter and sequencer sharing one instance of the team's 16-bit adder/subtractor (SixTeenBitAddSub) among up to four requesters. Accepts one add/sub command at a time over a valid/ready handshake, registers operands, runs the shared adder, and returns sum, carry and overflow tagged with the requester ID over a valid/ready response channel. Sits between the sprite-engine clients and the arithmetic datapath.

## Interface
- NREQ, 4, number of requesters (2..4)
- CNTW, 8, width of the saturating overflow counter
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  NREQ  per-requester command valid
- req_ready  output  NREQ  per-requester accept; one-hot or zero
- req_a  input  16*NREQ  operand A, requester i at [16i+15:16i]
- req_b  input  16*NREQ  operand B, same packing
- req_mode  input  NREQ  0 = A+B, 1 = A−B
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_id  output  2  index of requester that issued the command
- rsp_sum  output  16  adder sum
- rsp_carry  output  1  adder carry-out (bit-15 carry)
- rsp_ovf  output  1  signed overflow (c15 XOR c14)
- busy  output  1  high in EXEC or RESP
- ovf_cnt  output  CNTW  responses with rsp_ovf=1 since reset, saturating

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid, grant winner: first set bit of req_valid scanning from rr_ptr upward, wrapping mod NREQ. req_ready[winner]=1 combinationally that cycle; other bits 0. At edge: latch A, B, mode, id into op regs; rr_ptr <= (winner+1) mod NREQ; go EXEC. No req_valid: stay IDLE, rr_ptr unchanged.
- EXEC: adder driven from op regs (inputA=op_a, inputB=op_b, mode=op_mode). At edge: latch sum/carry/overflow/id into response regs, set rsp_valid, go RESP; if overflow=1, ovf_cnt increments unless at all-ones.
- RESP: rsp_valid=1, outputs stable. At edge with rsp_ready=1: clear rsp_valid, go IDLE. rsp_ready=0: hold indefinitely.
- req_ready is 0 in EXEC and RESP; requesters must hold req_valid and operands until accepted. Deasserting req_valid before acceptance withdraws the request.
- Arithmetic: 16-bit two's complement, wrap-around modulo 2^16; subtraction = A + ~B + 1; carry in subtraction is "no borrow".
- Response regs retain last values after handshake until next EXEC.
- Requester bits ≥ NREQ are absent; rsp_id upper bits zero when NREQ=2.

## Timing
- Reset (async assert, sync release): state IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_carry 0, rsp_ovf 0, busy 0, ovf_cnt 0.
- Accept edge E0 → rsp_valid high after E1 → earliest release at E2 → next accept at E3 edge (IDLE combinational ready in cycle after E2). Minimum 3 cycles per command.
- Reset mid-operation: in-flight command discarded, no response produced, counter cleared.
- Simultaneous requests: exactly one granted per IDLE cycle; a continuously requesting requester waits at most NREQ−1 other grants.
- rsp_ready asserted while rsp_valid=0 has no effect.
- ovf_cnt updates at the EXEC→RESP edge, i.e. visible with rsp_valid.

## Test plan
- Reset then single request: req 1 valid, A=0x0002, B=0x0002, mode 0 → req_ready[1] same cycle; rsp_valid two edges later with rsp_id=1, sum=0x0004, carry 0, ovf 0.
- Subtract with borrow: req 0, A=0x0000, B=0x000E, mode 1 → sum=0xFFF2, carry 0, ovf 0; A=0x000E, B=0x000C, mode 1 → sum=0x0002, carry 1.
- Overflow and counter: A=0x7FFF, B=0x0001, mode 0 → sum=0x8000, ovf 1, ovf_cnt=1; A=0xFFFF, B=0xFFFF, mode 0 → sum=0xFFFE, carry 1, ovf 0, ovf_cnt stays 1; 300 overflowing ops with CNTW=8 → ovf_cnt=0xFF.
- Round-robin fairness: all four req_valid held high → grant order 0,1,2,3,0; rsp_id matches; no requester granted twice before others.
- Backpressure: rsp_ready=0 for 10 cycles in RESP → rsp_valid and data stable, all req_ready 0, busy 1; rsp_ready=1 → IDLE next cycle.
- Reset mid-EXEC: pull rst_n low during EXEC → all outputs reset immediately, no rsp_valid after release, next grant starts from requester 0.
